// File: rtl/fifo_sp2b.sv
// Synchronous FIFO on two single-port RAM banks (even/odd addresses), with valid/ready on both sides.
// A one-entry pending-write register absorbs read/write bank collisions; a 2-entry output buffer hides read latency.
module fifo_sp2b #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int ROW_W = ADDR_WIDTH - 1;
   localparam int ROWS  = FIFO_DEPTH / 2;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH:0]   wptr, rptr, cptr;
   logic                  pend_valid, pend_bank;
   logic [ROW_W-1:0]      pend_row;
   logic [DATA_WIDTH-1:0] pend_data;
   logic                  inflight, inflight_bank;
   logic [1:0]            obuf_cnt;
   logic [DATA_WIDTH-1:0] obuf0, obuf1;

   logic                  push, pop, rd_issue, push_collide;
   logic                  push_bank, rd_bank;
   logic [ROW_W-1:0]      push_row, rd_row;
   logic [2:0]            occ_next;
   logic [DATA_WIDTH-1:0] cap_data;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign s_ready = ~full;
   assign m_valid = (obuf_cnt != 2'd0);
   assign m_data  = obuf0;

   assign push = s_valid & s_ready;
   assign pop  = m_valid & m_ready;

   // Entries in the pending register are not yet in RAM, so reads stop short of them.
   assign cptr      = wptr - {{ADDR_WIDTH{1'b0}}, pend_valid};
   assign occ_next  = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign rd_issue  = (rptr != cptr) && (occ_next < 3'd2);
   assign rd_bank   = rptr[0];
   assign rd_row    = rptr[ADDR_WIDTH-1:1];
   assign push_bank = wptr[0];
   assign push_row  = wptr[ADDR_WIDTH-1:1];
   assign push_collide = push && rd_issue && (push_bank == rd_bank);

   for (genvar g = 0; g < 2; g++) begin : g_bank
      localparam logic B = 1'(g);
      logic [DATA_WIDTH-1:0] mem [ROWS];
      logic [DATA_WIDTH-1:0] dout;
      logic                  en, we;
      logic [ROW_W-1:0]      row;
      logic [DATA_WIDTH-1:0] wdata;

      // A pending write never targets the read bank: consecutive reads alternate banks.
      always_comb begin
         en    = 1'b0;
         we    = 1'b0;
         row   = '0;
         wdata = '0;
         if (rd_issue && rd_bank == B) begin
            en  = 1'b1;
            row = rd_row;
         end else if (pend_valid && pend_bank == B) begin
            en    = 1'b1;
            we    = 1'b1;
            row   = pend_row;
            wdata = pend_data;
         end else if (push && !push_collide && push_bank == B) begin
            en    = 1'b1;
            we    = 1'b1;
            row   = push_row;
            wdata = s_data;
         end
      end

      always_ff @(posedge clk) begin
         if (en) begin
            if (we) mem[row] <= wdata;
            else    dout     <= mem[row];
         end
      end
   end

   assign cap_data = inflight_bank ? g_bank[1].dout : g_bank[0].dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         pend_valid    <= 1'b0;
         pend_bank     <= 1'b0;
         pend_row      <= '0;
         pend_data     <= '0;
         inflight      <= 1'b0;
         inflight_bank <= 1'b0;
         obuf_cnt      <= 2'd0;
         obuf0         <= '0;
         obuf1         <= '0;
      end else begin
         if (push)     wptr <= wptr + 1'b1;
         if (rd_issue) rptr <= rptr + 1'b1;

         inflight      <= rd_issue;
         inflight_bank <= rd_bank;

         pend_valid <= push_collide;
         if (push_collide) begin
            pend_data <= s_data;
            pend_row  <= push_row;
            pend_bank <= push_bank;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         // Capture never sees a full buffer: reads issue only when there is room for the result.
         case ({inflight, pop})
            2'b01: begin
               obuf0    <= obuf1;
               obuf_cnt <= obuf_cnt - 2'd1;
            end
            2'b10: begin
               if (obuf_cnt == 2'd0) obuf0 <= cap_data;
               else                  obuf1 <= cap_data;
               obuf_cnt <= obuf_cnt + 2'd1;
            end
            2'b11: begin
               if (obuf_cnt == 2'd1) begin
                  obuf0 <= cap_data;
               end else begin
                  obuf0 <= obuf1;
                  obuf1 <= cap_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_sp2b.sv
// Directed and random checks of fifo_sp2b against a queue scoreboard.
module tb_fifo_sp2b;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid, s_ready, m_valid, m_ready, full, empty;
   logic [DW-1:0] s_data, m_data;
   logic [AW:0]   count;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] q [$];
   logic [DW-1:0] v;
   int            n_coll;

   fifo_sp2b #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_state();
      check("count", 32'(count), 32'(q.size()));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
      if (m_valid && q.size() > 0) check("m_data_head", 32'(m_data), 32'(q[0]));
   endtask

   task automatic check_reset_outputs();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
   endtask

   // Drive one cycle; the handshake is decided from outputs sampled before the edge.
   task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr);
      logic do_push, do_pop;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      do_push = sv & s_ready;
      do_pop  = mr & m_valid;
      if (do_pop && q.size() > 0) begin
         check("pop_data", 32'(m_data), 32'(q[0]));
         void'(q.pop_front());
      end
      if (do_push) q.push_back(sd);
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1);
      check("drain_done", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic          rsv, rmr;
      logic [DW-1:0] rsd;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      #3;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill latency: m_valid two edges after the first push.
      cycle(1'b1, 8'h11, 1'b0);
      check("t1_mvalid_e0", 32'(m_valid), 32'd0);
      cycle(1'b1, 8'h22, 1'b0);
      check("t1_mvalid_e1", 32'(m_valid), 32'd0);
      cycle(1'b1, 8'h33, 1'b0);
      check("t1_mvalid_e2", 32'(m_valid), 32'd1);
      check("t1_m_data", 32'(m_data), 32'h11);
      check("t1_count", 32'(count), 32'd3);
      check("t1_empty", 32'(empty), 32'd0);
      drain(20);

      // Fill to capacity, reject overflow, then drain in order.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
      check("t2_full", 32'(full), 32'd1);
      check("t2_s_ready", 32'(s_ready), 32'd0);
      check("t2_count", 32'(count), 32'd16);
      cycle(1'b1, 8'hAA, 1'b0);
      check("t2_overflow_count", 32'(count), 32'd16);
      cycle(1'b1, 8'h55, 1'b1);
      check("t2_pop_from_full_count", 32'(count), 32'd15);
      check("t2_full_deassert", 32'(full), 32'd0);
      drain(40);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      check("t2_empty_end", 32'(empty), 32'd1);
      check("t2_mvalid_end", 32'(m_valid), 32'd0);

      // Half full, then streaming; this fill level makes every cycle a bank collision.
      v = 8'h80;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, v, 1'b0);
         v = v + 8'd1;
      end
      repeat (4) cycle(1'b0, 8'h00, 1'b0);
      n_coll = 0;
      for (int i = 0; i < 100; i++) begin
         check("stream_s_ready", 32'(s_ready), 32'd1);
         check("stream_m_valid", 32'(m_valid), 32'd1);
         cycle(1'b1, v, 1'b1);
         v = v + 8'd1;
         check("stream_count", 32'(count), 32'd8);
         if (i < 20 && dut.pend_valid) n_coll++;
      end
      check("collisions_20", 32'(n_coll), 32'd20);

      // Reset while a pending write and a RAM read are both outstanding.
      for (int i = 0; i < 10 && !(dut.pend_valid && dut.inflight); i++) begin
         cycle(1'b1, v, 1'b1);
         v = v + 8'd1;
      end
      check("rst_precond", 32'(dut.pend_valid && dut.inflight), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      q.delete();
      s_valid = 1'b0;
      m_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) cycle(1'b0, 8'h00, 1'b1);
      check("post_rst_mvalid", 32'(m_valid), 32'd0);
      cycle(1'b1, 8'hA1, 1'b0);
      cycle(1'b1, 8'hA2, 1'b0);
      cycle(1'b1, 8'hA3, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      check("post_rst_head", 32'(m_data), 32'hA1);
      drain(20);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         rsv = 1'($urandom_range(0, 1));
         rsd = 8'($urandom_range(0, 255));
         rmr = 1'($urandom_range(0, 1));
         cycle(rsv, rsd, rmr);
      end
      drain(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_sp2b.md
# fifo_sp2b

Synchronous FIFO built on two single-port RAM banks, even and odd addresses, with valid/ready handshakes on both sides. It sustains one write and one read per cycle indefinitely, without dual-port memory. A one-entry pending-write register resolves bank collisions, and a two-entry output buffer hides RAM read latency. It sits between streaming producers and consumers wherever a fifo_bank-style single-port store is too slow for simultaneous traffic.

## Interface
- DATA_WIDTH, 8, payload width.
- FIFO_DEPTH, 16, total capacity in entries; power of 2, ≥4; each bank holds FIFO_DEPTH/2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer index width; pointers carry one extra wrap bit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  producer has data.
- s_ready  out  1  FIFO accepts data; equals count < FIFO_DEPTH.
- s_data  in  DATA_WIDTH  write payload.
- m_valid  out  1  output buffer non-empty.
- m_ready  in  1  consumer takes data.
- m_data  out  DATA_WIDTH  head of output buffer.
- count  out  ADDR_WIDTH+1  entries held, 0..FIFO_DEPTH.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.

## Operation
- push = s_valid & s_ready; pop = m_valid & m_ready.
- count increments on push and decrements on pop; both together leave it unchanged.
- wptr and rptr are each ADDR_WIDTH+1 bits. Bank = ptr[0]; row = ptr[ADDR_WIDTH-1:1]. Both pointers wrap naturally modulo 2·FIFO_DEPTH.
- Each bank is a sync single-port RAM: one access per cycle, read data valid the cycle after access, no reset of contents. It is inferred inside the block.
- committed pointer cptr = wptr − pend_valid. A RAM read may issue only when rptr != cptr.
- Read issue condition: rptr != cptr and (obuf_cnt + inflight − pop) < 2. On issue, bank rptr[0] reads row, inflight=1 next cycle, rptr++.
- Bank arbitration per cycle, in priority order:
  1. RAM read, when issued.
  2. pending write; its bank never collides with the read, since reads alternate banks.
  3. incoming push write.
- Incoming push to wptr:
  - If its bank is free this cycle, it writes directly.
  - If its bank is taken by the read, it is captured into the pending register {data, row, bank} and pend_valid=1.
  - wptr++ either way.
- A pending write always commits the cycle after capture. If a new push collides in that same cycle, it reloads the pending register, so pend_valid stays 1.
- Output buffer: 2-entry FIFO. It captures RAM dout when inflight=1 and pops on pop; m_data is the head entry.
- Capacity holds: RAM-resident entries = count − obuf_cnt − inflight ≤ FIFO_DEPTH. No overwrite of unread rows is possible.
- Data order is strictly preserved, including across pending writes and pointer wrap.

## Timing
- Reset values (asynchronous, immediate):
  - s_ready=1, m_valid=0, m_data=0, count=0, full=0, empty=1.
  - wptr=rptr=0, pend_valid=0, inflight=0, obuf_cnt=0.
- Reset mid-operation discards all contents, including pending and inflight entries. RAM contents are don't-care.
- Latency from push at edge E0 to m_valid:
  - Bank free: RAM write at E0, read at E1, capture at E2; m_valid=1 after E2.
  - Push pended: one extra cycle; m_valid=1 after E3.
- Throughput: with s_valid=m_ready=1 continuously, after fill, push and pop both occur every cycle with no bubbles.
- full deasserts in the cycle after a pop from a full FIFO; a push in the same cycle as that pop is not accepted, because s_ready is registered-count based.
- empty and count update on the edge of the handshake. empty=0 does not imply m_valid=1 during the 2–3 cycle fill latency.
- s_ready does not depend on m_ready combinationally. m_valid does not depend on s_valid combinationally.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 with m_ready=0 -> count=3, m_valid rises 2 cycles after the first push edge, m_data=0x11, empty=0.
- Fill 16 entries (values 0..15) with m_ready=0 -> full=1, s_ready=0. A 17th s_valid is ignored. Draining yields 0..15 in order, then empty=1, m_valid=0.
- Continuous s_valid=m_ready=1 for 100 cycles with an incrementing pattern, starting half full -> one push and one pop every cycle, output strictly incrementing, count constant at 8.
- Force read/write same-bank collisions (rptr[0]==wptr[0] with both active) for 20 consecutive cycles -> pend_valid toggles or holds, no data loss or reorder, pointers wrap past 31 correctly.
- Random s_valid/m_ready at 50% for 10k cycles against a scoreboard -> all data matches; count equals scoreboard depth; full/empty consistent.
- Assert rst_n=0 mid-stream with pend_valid=1 and inflight=1 -> all outputs at reset values immediately. After release, the FIFO behaves as freshly reset and returns no stale data.
